sdram_cmd_responder: RTL and testbench
======================================

Name: sdram_cmd_responder

Overview:
Responder end of the SDRAM user command interface: accepts write/read requests from an initiator such as the SDRAM test module and services them from on-chip block RAM with SDRAM-like timing. Timing features are power-up init, CAS latency, write recovery and periodic refresh busy windows. It lets the test initiator be run and debugged on the MAX10 without the external SDRAM, and it doubles as the bench model for initiators. Interface semantics match the existing controller: valid/busy/recievedCommand/dataAvailable.

Parameters:
ADDR_WIDTH, 25, request address width
DATA_WIDTH, 16, data word width
MEM_ADDR_BITS, 16, implemented RAM index bits (address[MEM_ADDR_BITS-1:0]; upper bits alias)
INIT_CYCLES, 16, busy cycles after reset release
CAS_LATENCY, 3, read latency term (>=1)
WRITE_CYCLES, 3, write busy duration (effective value max(3,WRITE_CYCLES))
REFRESH_INTERVAL, 1117, cycles between refresh requests (7.8us at 143MHz)
REFRESH_CYCLES, 9, busy cycles per refresh

Ports:
inputClock  in  1  system clock, 143MHz
reset_n  in  1  asynchronous, active-low reset
inputValid  in  1  initiator request valid; fields stable while high
inputIsWriting  in  1  1=write, 0=read
inputAddress  in  ADDR_WIDTH  request address
inputData  in  DATA_WIDTH  write data
isBusy  out  1  responder cannot accept
recievedCommand  out  1  one-cycle pulse: request latched
outputDataAvailable  out  1  one-cycle pulse: outputData holds read result
outputData  out  DATA_WIDTH  read data, held between pulses
commandCount  out  32  accepted commands, wraps at 2^32

Behaviour:
- Reset (async assert, sync release): isBusy=1, recievedCommand=0, outputDataAvailable=0, outputData=0, commandCount=0, refresh counter=0, no refresh pending, state INIT. RAM contents not cleared. Reset mid-operation aborts any command; a pending RAM write may or may not land.
- States: INIT, IDLE, WRITE, READ_WAIT, READ_RETURN, REFRESH.
- INIT: isBusy=1 for INIT_CYCLES cycles after release, then IDLE with isBusy=0.
- Refresh counter free-runs from reset release. On reaching REFRESH_INTERVAL-1 it reloads 0 and sets refresh-pending; a second expiry while pending is absorbed, not queued.
- IDLE with refresh-pending: enter REFRESH at next edge. isBusy=1 for REFRESH_CYCLES cycles, then clear pending, return IDLE. Refresh wins over a simultaneous inputValid; the request stays waiting.
- IDLE, no pending, inputValid=1 sampled at edge E0: at E0 latch address/data/direction; register recievedCommand=1 (exactly one cycle), isBusy=1; commandCount+1.
- inputValid is ignored whenever isBusy=1. The initiator may hold a stale valid up to 2 cycles after the recievedCommand pulse. The minimum 3-cycle busy guarantees no double accept.
- WRITE: RAM[addr idx] <= data at E0+1. isBusy falls at edge E0+max(3,WRITE_CYCLES).
- READ: RAM read issued E0+1. At edge E0+CAS_LATENCY+1: outputData=RAM word and outputDataAvailable=1 for one cycle, isBusy still 1. isBusy falls at the following edge, never the same edge. When E0+CAS_LATENCY+2 < E0+3, busy is extended to E0+3.
- isBusy low for at least one cycle in IDLE between consecutive commands and refreshes.
- Address aliasing: only address[MEM_ADDR_BITS-1:0] indexes RAM. With the default 16 bits, a full 25-bit sweep writing data=address[15:0] reads back consistently.
- outputDataAvailable never asserts for writes. recievedCommand never asserts outside IDLE acceptance.

Decomposition:
- Package sdram_if_pkg: ADDR_WIDTH/DATA_WIDTH defaults, state enum typedef, timing default constants shared with the controller and the test module.
- Sub-module sdram_model_ram: single-port synchronous RAM, 2^MEM_ADDR_BITS x DATA_WIDTH, registered read, inferred to MAX10 block RAM.

Test Plan:
- Reset release -> isBusy=1 for exactly 16 cycles, then 0; all other outputs 0, commandCount=0.
- Write addr 0x0000123 data 0xBEEF at E0, then read same addr at E1 -> recievedCommand one pulse each; read outputDataAvailable at E1+4 with outputData=0xBEEF; isBusy falls at E1+5; commandCount=2.
- inputValid held high 2 cycles past recievedCommand -> no second accept; commandCount increments by 1 only.
- Refresh expiry coincident with inputValid in IDLE -> REFRESH first, isBusy=1 for 9 cycles. Request accepted only after isBusy returns low for one cycle.
- Write 0x1A5A5 then read 0x0A5A5 with data 0x1234 -> read returns 0x1234 (aliasing on bits above 15).
- Connect SDRAM test module with counterMax reduced to 70000 -> completedSuccess=1, compareError=0. Assert reset_n mid-read -> outputDataAvailable never pulses, responder re-runs INIT.

Source files
------------

// File: rtl/sdram_if_pkg.sv
// rtl/sdram_if_pkg.sv - shared SDRAM user-interface widths, timing defaults and responder states
package sdram_if_pkg;

  localparam int DEFAULT_ADDR_WIDTH       = 25;
  localparam int DEFAULT_DATA_WIDTH       = 16;
  localparam int DEFAULT_INIT_CYCLES      = 16;
  localparam int DEFAULT_CAS_LATENCY      = 3;
  localparam int DEFAULT_WRITE_CYCLES     = 3;
  localparam int DEFAULT_REFRESH_INTERVAL = 1117;
  localparam int DEFAULT_REFRESH_CYCLES   = 9;

  // Shortest busy window after an accept; covers an initiator's stale valid.
  localparam int MIN_COMMAND_CYCLES       = 3;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WRITE,
    READ_WAIT,
    READ_RETURN,
    REFRESH
  } responderState_t;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sdram_model_ram.sv
// rtl/sdram_model_ram.sv - single-port block RAM with registered read
module sdram_model_ram #(
  parameter int ADDR_BITS  = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  inputClock,
  input  logic                  writeEnable,
  input  logic [ADDR_BITS-1:0]  address,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] readData
);

  logic [DATA_WIDTH-1:0] memory [0:(1<<ADDR_BITS)-1];

  // Plain synchronous port, no reset, so it maps onto block RAM.
  always_ff @(posedge inputClock) begin
    if (writeEnable) begin
      memory[address] <= writeData;
    end
    readData <= memory[address];
  end

endmodule

// File: rtl/sdram_cmd_responder.sv
// rtl/sdram_cmd_responder.sv - block-RAM backed responder with SDRAM-like command timing
import sdram_if_pkg::*;

module sdram_cmd_responder #(
  parameter int ADDR_WIDTH       = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH       = DEFAULT_DATA_WIDTH,
  parameter int MEM_ADDR_BITS    = 16,
  parameter int INIT_CYCLES      = DEFAULT_INIT_CYCLES,
  parameter int CAS_LATENCY      = DEFAULT_CAS_LATENCY,
  parameter int WRITE_CYCLES     = DEFAULT_WRITE_CYCLES,
  parameter int REFRESH_INTERVAL = DEFAULT_REFRESH_INTERVAL,
  parameter int REFRESH_CYCLES   = DEFAULT_REFRESH_CYCLES
) (
  input  logic                  inputClock,
  input  logic                  reset_n,
  input  logic                  inputValid,
  input  logic                  inputIsWriting,
  input  logic [ADDR_WIDTH-1:0] inputAddress,
  input  logic [DATA_WIDTH-1:0] inputData,
  output logic                  isBusy,
  output logic                  recievedCommand,
  output logic                  outputDataAvailable,
  output logic [DATA_WIDTH-1:0] outputData,
  output logic [31:0]           commandCount
);

  localparam int WriteBusy   = maxInt(MIN_COMMAND_CYCLES, WRITE_CYCLES);
  // With CAS_LATENCY >= 1 the return edge plus one already meets the minimum;
  // the max keeps the busy floor if someone lowers the latency term.
  localparam int ReadBusy    = maxInt(MIN_COMMAND_CYCLES, CAS_LATENCY + 2);
  localparam int RefreshBits = $clog2(REFRESH_INTERVAL + 1);

  responderState_t          state;
  logic [15:0]              phaseCount;
  logic [RefreshBits-1:0]   refreshCount;
  logic                     refreshPending;
  logic                     refreshExpire;
  logic [MEM_ADDR_BITS-1:0] latchedAddress;
  logic [DATA_WIDTH-1:0]    latchedData;
  logic                     ramWriteEnable;
  logic [DATA_WIDTH-1:0]    ramReadData;

  // Address bits above the RAM index simply alias onto lower words.
  generate
    if (ADDR_WIDTH > MEM_ADDR_BITS) begin : gen_alias
      logic unusedAddressBits;
      assign unusedAddressBits = ^inputAddress[ADDR_WIDTH-1:MEM_ADDR_BITS];
    end
  endgenerate

  assign refreshExpire  = (refreshCount == RefreshBits'(REFRESH_INTERVAL - 1));
  // The write lands on the edge after acceptance, from the latched fields.
  assign ramWriteEnable = (state == WRITE) && (phaseCount == 16'd0);

  sdram_model_ram #(
    .ADDR_BITS  (MEM_ADDR_BITS),
    .DATA_WIDTH (DATA_WIDTH)
  ) modelRam (
    .inputClock  (inputClock),
    .writeEnable (ramWriteEnable),
    .address     (latchedAddress),
    .writeData   (latchedData),
    .readData    (ramReadData)
  );

  // Command FSM, refresh timer and all registered interface outputs.
  always_ff @(posedge inputClock or negedge reset_n) begin
    if (!reset_n) begin
      state               <= INIT;
      phaseCount          <= '0;
      refreshCount        <= '0;
      refreshPending      <= 1'b0;
      latchedAddress      <= '0;
      latchedData         <= '0;
      isBusy              <= 1'b1;
      recievedCommand     <= 1'b0;
      outputDataAvailable <= 1'b0;
      outputData          <= '0;
      commandCount        <= '0;
    end else begin
      recievedCommand     <= 1'b0;
      outputDataAvailable <= 1'b0;
      refreshCount        <= refreshExpire ? '0 : refreshCount + 1'b1;

      case (state)
        INIT: begin
          if (phaseCount == 16'(INIT_CYCLES - 1)) begin
            state      <= IDLE;
            isBusy     <= 1'b0;
            phaseCount <= '0;
          end else begin
            phaseCount <= phaseCount + 16'd1;
          end
        end
        IDLE: begin
          phaseCount <= '0;
          if (refreshPending) begin
            state  <= REFRESH;
            isBusy <= 1'b1;
          end else if (inputValid) begin
            state           <= inputIsWriting ? WRITE : READ_WAIT;
            isBusy          <= 1'b1;
            recievedCommand <= 1'b1;
            commandCount    <= commandCount + 32'd1;
            latchedAddress  <= inputAddress[MEM_ADDR_BITS-1:0];
            latchedData     <= inputData;
          end
        end
        WRITE: begin
          if (phaseCount == 16'(WriteBusy - 1)) begin
            state  <= IDLE;
            isBusy <= 1'b0;
          end else begin
            phaseCount <= phaseCount + 16'd1;
          end
        end
        READ_WAIT: begin
          phaseCount <= phaseCount + 16'd1;
          if (phaseCount == 16'(CAS_LATENCY)) begin
            state               <= READ_RETURN;
            outputData          <= ramReadData;
            outputDataAvailable <= 1'b1;
          end
        end
        READ_RETURN: begin
          if (phaseCount >= 16'(ReadBusy - 1)) begin
            state  <= IDLE;
            isBusy <= 1'b0;
          end else begin
            phaseCount <= phaseCount + 16'd1;
          end
        end
        REFRESH: begin
          if (phaseCount == 16'(REFRESH_CYCLES - 1)) begin
            state          <= IDLE;
            isBusy         <= 1'b0;
            refreshPending <= 1'b0;
          end else begin
            phaseCount <= phaseCount + 16'd1;
          end
        end
        default: begin
          state  <= INIT;
          isBusy <= 1'b1;
        end
      endcase

      // A new expiry always (re)arms the request; while pending it is absorbed.
      if (refreshExpire) begin
        refreshPending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_cmd_responder.sv
// tb/tb_sdram_cmd_responder.sv - directed self-checking bench for sdram_cmd_responder
module tb_sdram_cmd_responder;

  logic        inputClock = 1'b0;
  logic        reset_n;
  logic        inputValid;
  logic        inputIsWriting;
  logic [24:0] inputAddress;
  logic [15:0] inputData;
  logic        isBusy;
  logic        recievedCommand;
  logic        outputDataAvailable;
  logic [15:0] outputData;
  logic [31:0] commandCount;

  int checkCount = 0;
  int failCount  = 0;
  int edgeNum    = 0;

  always #5 inputClock = ~inputClock;

  sdram_cmd_responder dut (
    .inputClock          (inputClock),
    .reset_n             (reset_n),
    .inputValid          (inputValid),
    .inputIsWriting      (inputIsWriting),
    .inputAddress        (inputAddress),
    .inputData           (inputData),
    .isBusy              (isBusy),
    .recievedCommand     (recievedCommand),
    .outputDataAvailable (outputDataAvailable),
    .outputData          (outputData),
    .commandCount        (commandCount)
  );

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge inputClock);
    edgeNum++;
    #1;
  endtask

  task automatic setRequest(input logic v, input logic w, input logic [24:0] a, input logic [15:0] d);
    inputValid     = v;
    inputIsWriting = w;
    inputAddress   = a;
    inputData      = d;
  endtask

  task automatic issueWrite(input string tag, input logic [24:0] a, input logic [15:0] d, input int expCount);
    setRequest(1'b1, 1'b1, a, d);
    tick();
    checkValue({tag, "_accept"}, recievedCommand, 1);
    checkValue({tag, "_count"}, commandCount, expCount);
    setRequest(1'b0, 1'b0, '0, '0);
    tick();
    checkValue({tag, "_pulse_once"}, recievedCommand, 0);
    tick();
    checkValue({tag, "_no_avail"}, outputDataAvailable, 0);
    checkValue({tag, "_busy_e2"}, isBusy, 1);
    tick();
    checkValue({tag, "_busy_fall_e3"}, isBusy, 0);
  endtask

  task automatic issueRead(input string tag, input logic [24:0] a, input logic [15:0] expData, input int expCount);
    int e0;
    setRequest(1'b1, 1'b0, a, '0);
    tick();
    e0 = edgeNum;
    checkValue({tag, "_accept"}, recievedCommand, 1);
    checkValue({tag, "_count"}, commandCount, expCount);
    setRequest(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 20 && !outputDataAvailable; i++) tick();
    checkValue({tag, "_avail_edge"}, edgeNum - e0, 4);
    checkValue({tag, "_data"}, outputData, expData);
    checkValue({tag, "_busy_at_avail"}, isBusy, 1);
    tick();
    checkValue({tag, "_avail_once"}, outputDataAvailable, 0);
    checkValue({tag, "_busy_fall_e5"}, isBusy, 0);
    checkValue({tag, "_data_held"}, outputData, expData);
  endtask

  initial begin
    int busyFall;
    int availPulses;
    reset_n = 1'b0;
    setRequest(1'b0, 1'b0, '0, '0);
    tick(); tick(); tick();

    // Outputs while reset is held.
    checkValue("rst_busy", isBusy, 1);
    checkValue("rst_rc", recievedCommand, 0);
    checkValue("rst_avail", outputDataAvailable, 0);
    checkValue("rst_data", outputData, 0);
    checkValue("rst_count", commandCount, 0);

    // Init window: busy falls on the 16th edge after release.
    reset_n = 1'b1;
    edgeNum = 0;
    do tick(); while (isBusy && edgeNum < 100);
    checkValue("init_busy_edges", edgeNum, 16);
    checkValue("init_count", commandCount, 0);

    // Write then read back.
    issueWrite("wr123", 25'h0000123, 16'hBEEF, 1);
    issueRead("rd123", 25'h0000123, 16'hBEEF, 2);

    // Stale valid held two cycles beyond the accept pulse.
    setRequest(1'b1, 1'b1, 25'h55, 16'h1111);
    tick();
    checkValue("stale_accept", recievedCommand, 1);
    tick();
    checkValue("stale_ignored1", recievedCommand, 0);
    tick();
    checkValue("stale_ignored2", recievedCommand, 0);
    setRequest(1'b0, 1'b0, '0, '0);
    tick();
    checkValue("stale_busy_fall", isBusy, 0);
    tick();
    checkValue("stale_count", commandCount, 3);

    // Upper address bits alias onto the same RAM word.
    issueWrite("wr_alias", 25'h001A5A5, 16'h1234, 4);
    issueRead("rd_alias", 25'h000A5A5, 16'h1234, 5);

    // Reset in the middle of a read: no return pulse, init re-runs.
    setRequest(1'b1, 1'b0, 25'h123, '0);
    tick();
    setRequest(1'b0, 1'b0, '0, '0);
    tick(); tick();
    reset_n = 1'b0;
    #1;
    checkValue("midrst_busy", isBusy, 1);
    checkValue("midrst_count", commandCount, 0);
    checkValue("midrst_data", outputData, 0);
    tick();
    reset_n = 1'b1;
    edgeNum = 0;
    busyFall = 0;
    availPulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (outputDataAvailable) availPulses++;
      if (!isBusy && busyFall == 0) busyFall = edgeNum;
    end
    checkValue("midrst_no_avail", availPulses, 0);
    checkValue("midrst_reinit_edges", busyFall, 16);

    // Refresh pending at edge 1117 beats a request first seen at edge 1118.
    while (edgeNum < 1117) tick();
    checkValue("pre_refresh_idle", isBusy, 0);
    setRequest(1'b1, 1'b1, 25'h77, 16'h5A5A);
    tick();
    checkValue("refresh_busy_start", isBusy, 1);
    checkValue("refresh_not_accepted", recievedCommand, 0);
    while (edgeNum < 1126) tick();
    checkValue("refresh_busy_end", isBusy, 1);
    checkValue("refresh_count_hold", commandCount, 0);
    tick();
    checkValue("refresh_release", isBusy, 0);
    checkValue("refresh_release_rc", recievedCommand, 0);
    tick();
    checkValue("late_accept", recievedCommand, 1);
    checkValue("late_count", commandCount, 1);
    setRequest(1'b0, 1'b0, '0, '0);
    tick(); tick(); tick();
    checkValue("late_busy_fall", isBusy, 0);
    issueRead("rd_late", 25'h77, 16'h5A5A, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
